mpc_qp_admm_vec_ram_clr_1r1w: RTL

Parametrised simple-dual-port vector store for the ADMM QP solver's iterate vectors (z, u, V and similar), with one synchronous read port, one independent write port and a built-in clear sequencer. It replaces per-vector single-port RAMs so that one solver stage can read iterate k while another writes iterate k+1 in the same cycle. It re-zeroes the whole vector after reset and on request between MPC solves, so no HLS loop is spent on initialisation.

---
 rtl/mpc_qp_admm_vec_ram_clr_1r1w.sv | 99 +++++++++
 1 files changed

// File: rtl/mpc_qp_admm_vec_ram_clr_1r1w.sv
// Purpose : simple-dual-port iterate-vector store with a built-in clear sequencer.
// Latency : 1-cycle registered read, 1-cycle write; clear takes AddressRange cycles.
// Backpr. : none; writes during a clear and out-of-range writes are silently dropped.
//
// Ports:
//   clk, reset          - clock (rising edge), asynchronous active-low reset
//   address0, ce0, q0   - read port: address, enable, registered data
//   address1, ce1, we1, d1 - write port: address, enable, strobe, data
//   clear_start         - request a full clear (sampled in IDLE only)
//   clear_busy          - clear in progress
//   clear_done          - one-cycle pulse after the last clear write
module mpc_qp_admm_vec_ram_clr_1r1w #(
  parameter int                   DataWidth    = 32,
  parameter int                   AddressWidth = 5,
  parameter int                   AddressRange = 24,
  parameter int                   WriteFirst   = 0,
  parameter logic [DataWidth-1:0] ClearValue   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0,
  input  logic [AddressWidth-1:0] address1,
  input  logic                    ce1,
  input  logic                    we1,
  input  logic [DataWidth-1:0]    d1,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);
  // One extra bit so the range compare is correct even when AddressRange == 2^AddressWidth.
  localparam logic [AddressWidth:0]   RangeExt = (AddressWidth + 1)'(AddressRange);

  state_t                  state, state_nxt;
  logic [AddressWidth-1:0] clr_addr;
  logic [DataWidth-1:0]    ram [AddressRange];

  logic rd_in_range, wr_in_range, wr_en, clr_last, collide;

  assign rd_in_range = {1'b0, address0} < RangeExt;
  assign wr_in_range = {1'b0, address1} < RangeExt;
  assign wr_en       = (state == IDLE) && ce1 && we1 && wr_in_range;
  assign clr_last    = (clr_addr == LastAddr);
  assign collide     = wr_en && (address0 == address1);
  assign clear_busy  = (state == CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last)    state_nxt = IDLE;
      IDLE:    if (clear_start) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // The counter parks on the last address when leaving CLEAR; a new clear reloads 0,
  // so it never runs past AddressRange-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= (state == CLEAR) && clr_last;
      if (state == CLEAR) begin
        if (!clr_last) clr_addr <= clr_addr + 1'b1;
      end else if (clear_start) begin
        clr_addr <= '0;
      end
    end
  end

  // Storage is deliberately not reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  ram[clr_addr] <= ClearValue;
    else if (wr_en)      ram[address1] <= d1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0 <= '0;
    end else if (ce0) begin
      if (state == CLEAR)                  q0 <= ClearValue;
      else if (!rd_in_range)               q0 <= '0;
      else if ((WriteFirst != 0) && collide) q0 <= d1;
      else                                 q0 <= ram[address0];
    end
  end

endmodule
